// File: rtl/pagerank_sched_pkg.sv
// Shared types and constants for the PageRank iteration scheduler.
package pagerank_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_THREADS,
    STREAM,
    WAIT_FINAL,
    CHECK,
    CLEAR,
    DONE
  } sched_state_t;

  localparam logic [15:0] SCHED_TIMEOUT_CYCLES = 16'hFFFF;

  function automatic logic is_busy(input sched_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/thread_done_tracker.sv
// Sticky completion mask for the DMP partition threads; all_done also
// counts pulses arriving in the same cycle so the scheduler loses no cycle.
module thread_done_tracker #(
  parameter int NUM_HW_THREADS = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      capture,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  output logic                      all_done
);

  logic [NUM_HW_THREADS-1:0] mask_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
    end else if (clear) begin
      mask_reg <= '0;
    end else if (capture) begin
      mask_reg <= mask_reg | thread_done;
    end
  end

  assign all_done = capture && (&(mask_reg | thread_done));

endmodule

// File: rtl/pagerank_iteration_scheduler.sv
// Sequences PageRank iterations: launch threads, stream to the final damping
// stage, test convergence. Optional watchdog: PAGERANK_SCHED_TIMEOUT_EN.
module pagerank_iteration_scheduler
  import pagerank_sched_pkg::*;
#(
  parameter  int NUM_HW_THREADS = 8,
  parameter  int MAX_ITERATIONS = 64,
  localparam int ITER_W         = $clog2(MAX_ITERATIONS + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [63:0]               epsilon,
  output logic [NUM_HW_THREADS-1:0] thread_start,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  output logic                      stream_start,
  output logic                      stream_done,
  input  logic                      final_complete,
  input  logic [63:0]               delta,
  output logic                      iter_clear,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic [ITER_W-1:0]         iteration_count,
  output logic                      timeout
);

  sched_state_t      state_reg, state_next;
  logic [ITER_W-1:0] iter_count_reg;
  logic [ITER_W-1:0] iter_inc;
  logic              converged_reg;
  logic [63:0]       delta_reg;
  logic              delta_below;
  logic              all_done;
  logic              wd_expired;

  thread_done_tracker #(
    .NUM_HW_THREADS(NUM_HW_THREADS)
  ) u_tracker (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (state_reg == LAUNCH),
    .capture    (state_reg == WAIT_THREADS),
    .thread_done(thread_done),
    .all_done   (all_done)
  );

  assign iter_inc    = iter_count_reg + ITER_W'(1);
  assign delta_below = delta_reg < epsilon;

`ifdef PAGERANK_SCHED_TIMEOUT_EN
  logic [15:0] wd_reg;
  logic        timeout_reg;

  assign wd_expired = ((state_reg == WAIT_THREADS) || (state_reg == WAIT_FINAL))
                      && (wd_reg == SCHED_TIMEOUT_CYCLES);

  // Restarts whenever the state moves, so each wait is bounded on its own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_reg <= '0;
    end else if ((state_next != state_reg) ||
                 !((state_reg == WAIT_THREADS) || (state_reg == WAIT_FINAL))) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_reg <= 1'b0;
    end else if (!is_busy(state_reg)) begin
      if (start) timeout_reg <= 1'b0;
    end else if (!abort && wd_expired) begin
      timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    thread_start = '0;
    stream_start = 1'b0;
    stream_done  = 1'b0;
    iter_clear   = 1'b0;
    case (state_reg)
      IDLE:         if (start) state_next = LAUNCH;
      LAUNCH: begin
        thread_start = '1;
        state_next   = WAIT_THREADS;
      end
      WAIT_THREADS: if (all_done) state_next = STREAM;
      STREAM: begin
        stream_start = 1'b1;
        state_next   = WAIT_FINAL;
      end
      WAIT_FINAL: begin
        stream_done = 1'b1;
        if (final_complete) state_next = CHECK;
      end
      CHECK: begin
        if (delta_below || (iter_inc == ITER_W'(MAX_ITERATIONS))) state_next = DONE;
        else                                                       state_next = CLEAR;
      end
      CLEAR: begin
        iter_clear = 1'b1;
        state_next = LAUNCH;
      end
      DONE:         if (start) state_next = LAUNCH;
      default:      state_next = IDLE;
    endcase
    if (wd_expired) begin
      iter_clear = 1'b1;
      state_next = DONE;
    end
    // Abort wins over every other transition, including the watchdog.
    if (abort && is_busy(state_reg)) begin
      iter_clear = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      iter_count_reg <= '0;
      converged_reg  <= 1'b0;
      delta_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (!is_busy(state_reg)) begin
        if (start) begin
          iter_count_reg <= '0;
          converged_reg  <= 1'b0;
        end
      end else if (abort) begin
        converged_reg <= 1'b0;
      end else begin
        if ((state_reg == WAIT_FINAL) && final_complete) delta_reg <= delta;
        if (state_reg == CHECK) begin
          iter_count_reg <= iter_inc;
          converged_reg  <= delta_below;
        end
        if (wd_expired) converged_reg <= 1'b0;
      end
    end
  end

  assign busy            = is_busy(state_reg);
  assign done            = (state_reg == DONE);
  assign converged       = converged_reg;
  assign iteration_count = iter_count_reg;

endmodule

// File: tb/tb_pagerank_iteration_scheduler.sv
// Directed + randomized bench for pagerank_iteration_scheduler with a
// transaction-level expectation model (delays, delta/epsilon, iteration cap).
module tb_pagerank_iteration_scheduler;

  localparam int NT   = 8;
  localparam int MAXI = 3;
  localparam int IW   = $clog2(MAXI + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [63:0]   epsilon;
  logic [NT-1:0] thread_start;
  logic [NT-1:0] thread_done;
  logic          stream_start;
  logic          stream_done;
  logic          final_complete;
  logic [63:0]   delta;
  logic          iter_clear;
  logic          busy;
  logic          done;
  logic          converged;
  logic [IW-1:0] iteration_count;
  logic          timeout;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int ts_cnt = 0;
  int ic_cnt = 0;
  int dly [NT];

  pagerank_iteration_scheduler #(
    .NUM_HW_THREADS(NT),
    .MAX_ITERATIONS(MAXI)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .epsilon        (epsilon),
    .thread_start   (thread_start),
    .thread_done    (thread_done),
    .stream_start   (stream_start),
    .stream_done    (stream_done),
    .final_complete (final_complete),
    .delta          (delta),
    .iter_clear     (iter_clear),
    .busy           (busy),
    .done           (done),
    .converged      (converged),
    .iteration_count(iteration_count),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (thread_start == '1) ts_cnt++;
    if (iter_clear) ic_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic launch;
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_count = 0;
    chk("launch_ts", 64'(thread_start), 64'hFF);
    chk("launch_busy", 64'(busy), 64'd1);
    chk("launch_done", 64'(done), 64'd0);
    chk("launch_cnt", 64'(iteration_count), 64'd0);
    chk("launch_conv", 64'(converged), 64'd0);
    chk("launch_tmo", 64'(timeout), 64'd0);
  endtask

  // Entered at the LAUNCH cycle; leaves at the next LAUNCH cycle, or in DONE/IDLE.
  task automatic run_iter(input logic [7:0] dup_bits, input logic [7:0] junk,
                          input int fdly, input logic [63:0] d,
                          input bit abort_final, output bit finished);
    int last;
    logic [7:0] seen;
    bit conv;
    finished = 1'b0;
    last = 1;
    for (int i = 0; i < NT; i++) if (dly[i] > last) last = dly[i];
    thread_done = junk;
    seen = '0;
    for (int k = 1; k <= last; k++) begin
      tick;
      chk("wait_ts", 64'(thread_start), 64'd0);
      chk("wait_ss", 64'(stream_start), 64'd0);
      start = 1'($urandom_range(1, 0));
      thread_done = dup_bits & seen;
      for (int i = 0; i < NT; i++) if (dly[i] == k) thread_done[i] = 1'b1;
      seen = seen | thread_done;
    end
    tick;
    chk("stream_start", 64'(stream_start), 64'd1);
    chk("stream_sd", 64'(stream_done), 64'd0);
    thread_done = junk;
    start = 1'b0;
    for (int k = 1; k <= fdly; k++) begin
      tick;
      chk("final_sd", 64'(stream_done), 64'd1);
      chk("final_ss", 64'(stream_start), 64'd0);
      thread_done = '0;
      delta = {$urandom, $urandom};
      if (k == fdly) begin
        if (abort_final) begin
          abort = 1'b1;
          #1;
          chk("abort_clear", 64'(iter_clear), 64'd1);
        end else begin
          final_complete = 1'b1;
          delta = d;
        end
      end
    end
    tick;
    final_complete = 1'b0;
    delta = {$urandom, $urandom};
    if (abort_final) begin
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_cnt", 64'(iteration_count), 64'(exp_count));
      chk("abort_conv", 64'(converged), 64'd0);
      chk("abort_ic", 64'(iter_clear), 64'd0);
      finished = 1'b1;
    end else begin
      chk("check_busy", 64'(busy), 64'd1);
      chk("check_ic", 64'(iter_clear), 64'd0);
      chk("check_cnt", 64'(iteration_count), 64'(exp_count));
      exp_count++;
      conv = (d < epsilon);
      final_complete = 1'b1;
      tick;
      final_complete = 1'b0;
      if (conv || exp_count == MAXI) begin
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_conv", 64'(converged), 64'(conv));
        chk("end_cnt", 64'(iteration_count), 64'(exp_count));
        chk("end_ic", 64'(iter_clear), 64'd0);
        finished = 1'b1;
      end else begin
        chk("clear_ic", 64'(iter_clear), 64'd1);
        chk("clear_done", 64'(done), 64'd0);
        chk("clear_cnt", 64'(iteration_count), 64'(exp_count));
        chk("clear_conv", 64'(converged), 64'd0);
        tick;
        chk("relaunch_ts", 64'(thread_start), 64'hFF);
        chk("relaunch_cnt", 64'(iteration_count), 64'(exp_count));
      end
    end
  endtask

  initial begin
    bit fin;
    logic [63:0] d;
    int n;
    int ic0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    epsilon = 64'd10;
    thread_done = '0;
    final_complete = 1'b0;
    delta = '0;
    tick;
    tick;
    chk("rst_ts", 64'(thread_start), 64'd0);
    chk("rst_ss", 64'(stream_start), 64'd0);
    chk("rst_sd", 64'(stream_done), 64'd0);
    chk("rst_ic", 64'(iter_clear), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_conv", 64'(converged), 64'd0);
    chk("rst_cnt", 64'(iteration_count), 64'd0);
    chk("rst_tmo", 64'(timeout), 64'd0);
    reset_n = 1'b1;
    tick;

    // Threads complete in order, delta below epsilon: one iteration.
    for (int i = 0; i < NT; i++) dly[i] = i + 1;
    launch;
    run_iter(8'h00, 8'h00, 1, 64'd5, 1'b0, fin);
    chk("ord_conv", 64'(converged), 64'd1);
    chk("ord_cnt", 64'(iteration_count), 64'd1);

    // Never converges: runs to the iteration cap.
    ts_cnt = 0;
    ic_cnt = 0;
    launch;
    for (int it = 0; it < MAXI; it++) run_iter(8'h00, 8'h00, 1, 64'd20, 1'b0, fin);
    chk("cap_conv", 64'(converged), 64'd0);
    chk("cap_cnt", 64'(iteration_count), 64'(MAXI));
    chk("cap_ts_pulses", 64'(ts_cnt), 64'(MAXI));
    chk("cap_ic_pulses", 64'(ic_cnt), 64'(MAXI - 1));

    // Thread 2 early and repeated, everyone else in one cycle.
    for (int i = 0; i < NT; i++) dly[i] = 3;
    dly[2] = 1;
    launch;
    run_iter(8'h04, 8'hFF, 2, 64'd5, 1'b0, fin);

    // Randomized runs; first uses epsilon = 0.
    for (int r = 0; r < 6; r++) begin
      epsilon = (r == 0) ? 64'd0 : ({$urandom, $urandom} | 64'h100);
      launch;
      fin = 1'b0;
      for (int it = 0; it < MAXI && !fin; it++) begin
        for (int i = 0; i < NT; i++) dly[i] = $urandom_range(4, 1);
        case ($urandom_range(3, 0))
          0:       d = epsilon - 64'd1;
          1:       d = epsilon;
          2:       d = epsilon + 64'($urandom);
          default: d = {$urandom, $urandom};
        endcase
        run_iter(8'($urandom), 8'($urandom), $urandom_range(3, 1), d, 1'b0, fin);
      end
      chk("rand_done", 64'(done), 64'd1);
    end

    // Abort in WAIT_FINAL of iteration 2.
    epsilon = 64'd10;
    for (int i = 0; i < NT; i++) dly[i] = $urandom_range(3, 1);
    launch;
    run_iter(8'h00, 8'h00, 1, 64'd20, 1'b0, fin);
    run_iter(8'h00, 8'h00, 2, 64'd20, 1'b1, fin);
    abort = 1'b1;
    #1;
    chk("idle_abort_ic", 64'(iter_clear), 64'd0);
    tick;
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_cnt", 64'(iteration_count), 64'd1);
    launch;

    // Reset asserted in STREAM.
    thread_done = '0;
    tick;
    thread_done = '1;
    tick;
    thread_done = '0;
    chk("pre_rst_ss", 64'(stream_start), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ss", 64'(stream_start), 64'd0);
    chk("mid_rst_ic", 64'(iter_clear), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ts", 64'(thread_start), 64'd0);
    tick;
    reset_n = 1'b1;
    final_complete = 1'b1;
    delta = 64'd0;
    tick;
    tick;
    final_complete = 1'b0;
    chk("stray_fc_busy", 64'(busy), 64'd0);
    chk("stray_fc_done", 64'(done), 64'd0);
    chk("stray_fc_sd", 64'(stream_done), 64'd0);
    chk("stray_fc_conv", 64'(converged), 64'd0);

    // Thread 7 never completes.
    launch;
    tick;
    thread_done = 8'h7F;
    tick;
    thread_done = '0;
    ic0 = ic_cnt;
`ifdef PAGERANK_SCHED_TIMEOUT_EN
    n = 1;
    while (!done && n < 70000) begin
      tick;
      n++;
    end
    chk("wd_done", 64'(done), 64'd1);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_conv", 64'(converged), 64'd0);
    chk("wd_ic_pulse", 64'(ic_cnt - ic0), 64'd1);
    chk("wd_window", 64'((n >= 65535) && (n <= 65537)), 64'd1);
`else
    n = 0;
    for (int c = 0; c < 70000; c++) begin
      tick;
      n++;
    end
    chk("nowd_done", 64'(done), 64'd0);
    chk("nowd_timeout", 64'(timeout), 64'd0);
    chk("nowd_busy", 64'(busy), 64'd1);
    chk("nowd_ic", 64'(ic_cnt - ic0), 64'd0);
    abort = 1'b1;
    #1;
    chk("nowd_abort_ic", 64'(iter_clear), 64'd1);
    tick;
    abort = 1'b0;
    chk("nowd_abort_busy", 64'(busy), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pagerank_iteration_scheduler.md
# pagerank_iteration_scheduler

Sequences PageRank iterations across the partition threads and the final damping stage (`DMP_serial_final`). It launches all `NUM_HW_THREADS` DMP partitions and collects their completions, then hands the stream to the final stage. It compares the returned `delta` against a convergence threshold and either clears the final stage for another iteration or stops at convergence or an iteration cap.

## Interface
- `NUM_HW_THREADS`, 8, number of graph partitions / DMP threads (1..32)
- `MAX_ITERATIONS`, 64, iteration cap (>=1)
- `ITER_W`, `$clog2(MAX_ITERATIONS+1)`, width of the iteration counter (localparam)
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled in IDLE or DONE
- `abort`  in  1  cancel a run in progress
- `epsilon`  in  64  convergence threshold, unsigned compare
- `thread_start`  out  NUM_HW_THREADS  one-cycle launch pulse, all bits together
- `thread_done`  in  NUM_HW_THREADS  per-thread completion pulse
- `stream_start`  out  1  one-cycle pulse to the final stage
- `stream_done`  out  1  level, high while waiting on the final stage
- `final_complete`  in  1  final stage's `pagerank_iteration_complete`
- `delta`  in  64  final stage's delta, valid while `final_complete`=1
- `iter_clear`  out  1  one-cycle clear to the final stage and thread accumulators
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  level, high in DONE
- `converged`  out  1  valid in DONE: 1 if `delta` < `epsilon`
- `iteration_count`  out  ITER_W  completed iterations in the current/last run
- `timeout`  out  1  watchdog expired; see Configuration

## Operation
- States:
  - IDLE: `start` -> LAUNCH; clears `iteration_count`, `converged`, `timeout`.
  - LAUNCH: `thread_start` = all ones for this one cycle; clears done-mask; -> WAIT_THREADS.
  - WAIT_THREADS: OR `thread_done` into a sticky mask; when (mask | `thread_done`) is all ones -> STREAM. Duplicate pulses are harmless.
  - STREAM: `stream_start`=1 for one cycle; -> WAIT_FINAL.
  - WAIT_FINAL: `stream_done`=1; on `final_complete` -> CHECK, latching `delta`.
  - CHECK: `iteration_count` += 1; `converged` <= (latched delta < `epsilon`).
    - Converged, or incremented count == `MAX_ITERATIONS` -> DONE.
    - Otherwise -> CLEAR.
  - CLEAR: `iter_clear`=1 for one cycle; -> LAUNCH.
  - DONE: `done`=1; holds `converged` and `iteration_count`; `start` -> LAUNCH with count, `converged`, `timeout` cleared.
- `abort` in any busy state:
  - `iter_clear`=1 combinationally that cycle, then -> IDLE.
  - `iteration_count` holds; `converged` forced 0.
  - `abort` has priority over all other transitions.
  - `abort` in IDLE/DONE is ignored.
- `thread_done` is ignored outside WAIT_THREADS.
- `final_complete` is ignored outside WAIT_FINAL.
- `start` while busy is ignored.
- `epsilon` = 0 never converges; the run ends at `MAX_ITERATIONS`.

## Timing
- Reset: state IDLE; all outputs 0; mask 0; latched delta 0; `iteration_count` 0.
- `start` at cycle N -> `thread_start` at N+1.
- Final `thread_done` at cycle M -> `stream_start` at M+1.
- `final_complete` at cycle K -> CHECK at K+1 -> `iter_clear` at K+2 (or `done` at K+2) -> next `thread_start` at K+3.
- Minimum iteration, with threads and final stage each completing the cycle after their request: 6 cycles.
- Reset assertion mid-run returns everything to reset values immediately (asynchronously); no `iter_clear` is emitted.

## Configuration
- `PAGERANK_SCHED_TIMEOUT_EN` defined:
  - 16-bit watchdog counter, reset on every state change, counts in WAIT_THREADS and WAIT_FINAL.
  - At 0xFFFF: `timeout`=1, `iter_clear` pulse, -> DONE with `converged`=0.
- Undefined: no counter is built; `timeout` is tied 0; waits are unbounded.

## Structure
- Package `pagerank_sched_pkg`:
  - State enum `sched_state_t` (IDLE, LAUNCH, WAIT_THREADS, STREAM, WAIT_FINAL, CHECK, CLEAR, DONE), `logic[2:0]`.
  - Watchdog constant `SCHED_TIMEOUT_CYCLES` = 16'hFFFF.
- Sub-module `thread_done_tracker`, parameterised by `NUM_HW_THREADS`:
  - Inputs: `clear`, `capture`, `thread_done`.
  - Output: `all_done`, which includes same-cycle pulses.

## Test plan
- Threads pulse `thread_done` in order 0..7, one per cycle; `final_complete` with `delta`=5, `epsilon`=10 -> single iteration; `done`=1, `converged`=1, `iteration_count`=1.
- `delta`=20 and `epsilon`=10 every time, `MAX_ITERATIONS`=3 -> three `thread_start` pulses, two `iter_clear` pulses; end with `converged`=0, `iteration_count`=3.
- All 8 `thread_done` bits pulsed in the same cycle, thread 2 pulsed twice early -> `stream_start` exactly once, on the next cycle.
- `abort` during WAIT_FINAL of iteration 2 -> `iter_clear` that cycle; IDLE next cycle; `iteration_count`=1; later `start` re-launches with count 0.
- `reset_n` low during STREAM -> all outputs 0 immediately; stray `final_complete` in IDLE is ignored.
- With `PAGERANK_SCHED_TIMEOUT_EN`, thread 7 never completes -> `timeout`=1 and `done`=1 after 65535 cycles in WAIT_THREADS; without the macro, the bench still waits at 70000 cycles with `timeout`=0.
